// File: rtl/shift_engine.sv
// shift_engine: N-bit parallel-load register that performs a multi-cycle shift or
// rotate of a requested number of single-position steps, with start/busy/done handshake.
module shift_engine #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = $clog2(N + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  R,
    input  logic          L,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          w,
    output logic [N-1:0]  Q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic          sout_q, sout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;

    logic [N-1:0]  step_q;
    logic          step_sout;

    // Single-position step result for the latched mode; reserved modes hold Q and sout.
    always_comb begin
        step_q    = q_q;
        step_sout = sout_q;
        case (mode_q)
            3'b000: begin
                step_q    = {q_q[N-2:0], w};
                step_sout = q_q[N-1];
            end
            3'b001: begin
                step_q    = {w, q_q[N-1:1]};
                step_sout = q_q[0];
            end
            3'b010: begin
                step_q    = {q_q[N-2:0], q_q[N-1]};
                step_sout = q_q[N-1];
            end
            3'b011: begin
                step_q    = {q_q[0], q_q[N-1:1]};
                step_sout = q_q[0];
            end
            3'b100: begin
                step_q    = {q_q[N-1], q_q[N-1:1]};
                step_sout = q_q[0];
            end
            default: begin
                step_q    = q_q;
                step_sout = sout_q;
            end
        endcase
    end

    // Next-state and datapath control; done is a one-cycle registered pulse.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (L) begin
                    q_d = R;
                end else if (start) begin
                    if (amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        cnt_d   = amt;
                        busy_d  = 1'b1;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                q_d    = step_q;
                sout_d = step_sout;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset that overrides any operation in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
